alu_issue: RTL and testbench

Instruction decode/issue stage that sits directly upstream of the ALU in the 9-bit CPU. It accepts 9-bit instruction words over a valid/ready handshake and assembles two-word load-immediates. It registers decoded control and operand-select fields that drive the ALU and register file for exactly one issue slot each. It owns the architectural carry and zero flags: the carry flag feeds the ALU carry-in, and both flags are updated from the ALU carry-out and zero outputs when an issue retires.

---
 rtl/alu_issue.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_issue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage in front of the 9-bit CPU ALU.
// Accepts instruction words over valid/ready and assembles two-word
// load-immediates. Each issue is held in registers for one issue slot.
// The stage also owns the architectural carry and zero flags.
module alu_issue (
    input  logic       CLK,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [8:0] instr,
    output logic       instr_ready,
    input  logic       stall,
    input  logic       alu_co,
    input  logic       alu_z,
    output logic       issue_valid,
    output logic [2:0] alu_op,
    output logic       alu_rsh,
    output logic       alu_ci,
    output logic [2:0] ra_addr,
    output logic [2:0] rb_addr,
    output logic       b_imm,
    output logic [7:0] imm,
    output logic       wr_en,
    output logic [2:0] wr_addr,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic       c_flag,
    output logic       z_flag,
    output logic       halted
);

    // Opcode encoding shared with the ALU
    localparam logic [2:0] K_AND  = 3'd0;
    localparam logic [2:0] K_ADD  = 3'd1;
    localparam logic [2:0] K_XOR  = 3'd2;
    localparam logic [2:0] K_LSH  = 3'd3;
    localparam logic [2:0] K_STR  = 3'd4;
    localparam logic [2:0] K_LDM  = 3'd5;
    localparam logic [2:0] K_LDI  = 3'd6;
    localparam logic [2:0] K_HALT = 3'd7;

    // Sequencer states
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_IMM  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [2:0] ldi_rd_r;
    logic [2:0] ldi_rd_next_s;

    logic       accept_s;
    logic       retire_s;
    logic [2:0] op_s;
    logic [2:0] rd_s;
    logic [2:0] rs_s;

    logic       d_issue_s;
    logic [2:0] d_op_s;
    logic       d_rsh_s;
    logic [2:0] d_ra_s;
    logic [2:0] d_rb_s;
    logic       d_b_imm_s;
    logic [7:0] d_imm_s;
    logic       d_wr_en_s;
    logic [2:0] d_wr_addr_s;
    logic       d_mem_wr_s;
    logic       d_mem_rd_s;

    assign op_s        = instr[8:6];
    assign rd_s        = instr[5:3];
    assign rs_s        = instr[2:0];
    assign instr_ready = !halted && (!issue_valid || !stall);
    assign accept_s    = instr_valid && instr_ready;
    assign retire_s    = issue_valid && !stall;

    // Carry-in tracks the live carry flag so an ADD issued right after an
    // ADD retires sees the freshly updated carry.
    assign alu_ci = (alu_op == K_ADD) ? c_flag : 1'b0;

    // Decode the accepted word into next-issue fields and next state
    always_comb begin
        state_next_s  = state_r;
        ldi_rd_next_s = ldi_rd_r;
        d_issue_s     = 1'b0;
        d_op_s        = 3'd0;
        d_rsh_s       = 1'b0;
        d_ra_s        = 3'd0;
        d_rb_s        = 3'd0;
        d_b_imm_s     = 1'b0;
        d_imm_s       = 8'd0;
        d_wr_en_s     = 1'b0;
        d_wr_addr_s   = 3'd0;
        d_mem_wr_s    = 1'b0;
        d_mem_rd_s    = 1'b0;
        if (accept_s) begin
            case (state_r)
                ST_RUN: begin
                    d_op_s = op_s;
                    case (op_s)
                        K_AND, K_ADD, K_XOR: begin
                            d_issue_s   = 1'b1;
                            d_ra_s      = rd_s;
                            d_rb_s      = rs_s;
                            d_wr_en_s   = 1'b1;
                            d_wr_addr_s = rd_s;
                        end
                        K_LSH: begin
                            d_issue_s   = 1'b1;
                            d_ra_s      = rd_s;
                            d_rsh_s     = instr[2];
                            d_imm_s     = {6'd0, instr[1:0]} + 8'd1;
                            d_b_imm_s   = 1'b1;
                            d_wr_en_s   = 1'b1;
                            d_wr_addr_s = rd_s;
                        end
                        K_STR: begin
                            d_issue_s  = 1'b1;
                            d_ra_s     = rd_s;
                            d_rb_s     = rs_s;
                            d_mem_wr_s = 1'b1;
                        end
                        K_LDM: begin
                            d_issue_s   = 1'b1;
                            d_rb_s      = rs_s;
                            d_mem_rd_s  = 1'b1;
                            d_wr_en_s   = 1'b1;
                            d_wr_addr_s = rd_s;
                        end
                        K_LDI: begin
                            ldi_rd_next_s = rd_s;
                            state_next_s  = ST_IMM;
                        end
                        K_HALT: begin
                            state_next_s = ST_HALT;
                        end
                        default: begin
                            state_next_s = ST_RUN;
                        end
                    endcase
                end
                ST_IMM: begin
                    // Second word is pure immediate data; bit 8 is ignored
                    d_issue_s    = 1'b1;
                    d_op_s       = K_LDI;
                    d_imm_s      = instr[7:0];
                    d_b_imm_s    = 1'b1;
                    d_wr_en_s    = 1'b1;
                    d_wr_addr_s  = ldi_rd_r;
                    state_next_s = ST_RUN;
                end
                ST_HALT: begin
                    state_next_s = ST_HALT;
                end
                default: begin
                    state_next_s = ST_RUN;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Sequencer state, captured LDI destination and sticky halt
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r  <= ST_RUN;
            ldi_rd_r <= 3'd0;
            halted   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            ldi_rd_r <= ldi_rd_next_s;
            halted   <= halted || (state_next_s == ST_HALT);
        end
    end

    // Issue slot: load on a decoding accept, drop valid on a bare retire
    always_ff @(posedge CLK) begin
        if (reset) begin
            issue_valid <= 1'b0;
            alu_op      <= 3'd0;
            alu_rsh     <= 1'b0;
            ra_addr     <= 3'd0;
            rb_addr     <= 3'd0;
            b_imm       <= 1'b0;
            imm         <= 8'd0;
            wr_en       <= 1'b0;
            wr_addr     <= 3'd0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else if (d_issue_s) begin
            issue_valid <= 1'b1;
            alu_op      <= d_op_s;
            alu_rsh     <= d_rsh_s;
            ra_addr     <= d_ra_s;
            rb_addr     <= d_rb_s;
            b_imm       <= d_b_imm_s;
            imm         <= d_imm_s;
            wr_en       <= d_wr_en_s;
            wr_addr     <= d_wr_addr_s;
            mem_wr      <= d_mem_wr_s;
            mem_rd      <= d_mem_rd_s;
        end else if (retire_s) begin
            issue_valid <= 1'b0;
        end
    end

    // Architectural flags, updated exactly once when an issue retires
    always_ff @(posedge CLK) begin
        if (reset) begin
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (retire_s) begin
            case (alu_op)
                K_ADD: begin
                    c_flag <= alu_co;
                    z_flag <= alu_z;
                end
                K_AND, K_XOR: begin
                    c_flag <= 1'b0;
                    z_flag <= alu_z;
                end
                K_LSH: begin
                    z_flag <= alu_z;
                end
                default: begin
                    c_flag <= c_flag;
                    z_flag <= z_flag;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
module tb_alu_issue;

    logic       CLK = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       stall;
    logic       alu_co;
    logic       alu_z;
    logic       issue_valid;
    logic [2:0] alu_op;
    logic       alu_rsh;
    logic       alu_ci;
    logic [2:0] ra_addr;
    logic [2:0] rb_addr;
    logic       b_imm;
    logic [7:0] imm;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic       mem_wr;
    logic       mem_rd;
    logic       c_flag;
    logic       z_flag;
    logic       halted;

    int total = 0;
    int bad   = 0;

    alu_issue dut (
        .CLK(CLK), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .stall(stall), .alu_co(alu_co), .alu_z(alu_z),
        .issue_valid(issue_valid), .alu_op(alu_op), .alu_rsh(alu_rsh),
        .alu_ci(alu_ci), .ra_addr(ra_addr), .rb_addr(rb_addr), .b_imm(b_imm),
        .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .c_flag(c_flag), .z_flag(z_flag), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs};
    endfunction

    task automatic do_reset();
        reset = 1'b1; instr_valid = 1'b0; stall = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        instr = 9'd0; alu_co = 1'b0; alu_z = 1'b0;
        do_reset();
        total++;
        if (issue_valid !== 1'b0 || instr_ready !== 1'b1 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: got iv=%b rdy=%b h=%b want 0 1 0", issue_valid, instr_ready, halted);
        end
        total++;
        if (c_flag !== 1'b0 || z_flag !== 1'b0 || alu_op !== 3'd0 || imm !== 8'd0 || wr_en !== 1'b0 || alu_ci !== 1'b0) begin
            bad++; $display("FAIL reset_fields: got c=%b z=%b op=%0d imm=%h we=%b ci=%b want all 0", c_flag, z_flag, alu_op, imm, wr_en, alu_ci);
        end
    endtask

    task automatic test_add();
        instr = mk(3'd1, 3'd1, 3'd2); instr_valid = 1'b1; alu_co = 1'b1; alu_z = 1'b0;
        cyc();
        instr_valid = 1'b0;
        total++;
        if (issue_valid !== 1'b1 || alu_op !== 3'd1 || ra_addr !== 3'd1 || rb_addr !== 3'd2 || alu_ci !== 1'b0
            || b_imm !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 3'd1) begin
            bad++; $display("FAIL add_issue: got iv=%b op=%0d ra=%0d rb=%0d ci=%b bi=%b we=%b wa=%0d want 1 1 1 2 0 0 1 1",
                issue_valid, alu_op, ra_addr, rb_addr, alu_ci, b_imm, wr_en, wr_addr);
        end
        cyc();
        total++;
        if (issue_valid !== 1'b0 || c_flag !== 1'b1 || z_flag !== 1'b0) begin
            bad++; $display("FAIL add_retire: got iv=%b c=%b z=%b want 0 1 0", issue_valid, c_flag, z_flag);
        end
    endtask

    task automatic test_back_to_back();
        instr = mk(3'd0, 3'd3, 3'd4); instr_valid = 1'b1; alu_co = 1'b0; alu_z = 1'b0;
        cyc();
        total++;
        if (alu_op !== 3'd0 || alu_ci !== 1'b0 || c_flag !== 1'b1) begin
            bad++; $display("FAIL b2b_and: got op=%0d ci=%b c=%b want 0 0 1", alu_op, alu_ci, c_flag);
        end
        instr = mk(3'd1, 3'd1, 3'd2);
        cyc();
        total++;
        if (issue_valid !== 1'b1 || alu_op !== 3'd1 || alu_ci !== 1'b0 || c_flag !== 1'b0) begin
            bad++; $display("FAIL b2b_add1: got iv=%b op=%0d ci=%b c=%b want 1 1 0 0", issue_valid, alu_op, alu_ci, c_flag);
        end
        alu_co = 1'b1;
        instr = mk(3'd1, 3'd2, 3'd3);
        cyc();
        total++;
        if (issue_valid !== 1'b1 || alu_op !== 3'd1 || ra_addr !== 3'd2 || alu_ci !== 1'b1 || c_flag !== 1'b1) begin
            bad++; $display("FAIL b2b_add2: got iv=%b op=%0d ra=%0d ci=%b c=%b want 1 1 2 1 1", issue_valid, alu_op, ra_addr, alu_ci, c_flag);
        end
        instr = mk(3'd2, 3'd4, 3'd5);
        cyc();
        instr_valid = 1'b0; alu_co = 1'b1; alu_z = 1'b1;
        total++;
        if (alu_op !== 3'd2 || alu_ci !== 1'b0 || c_flag !== 1'b1 || rb_addr !== 3'd5) begin
            bad++; $display("FAIL b2b_xor: got op=%0d ci=%b c=%b rb=%0d want 2 0 1 5", alu_op, alu_ci, c_flag, rb_addr);
        end
        cyc();
        total++;
        if (issue_valid !== 1'b0 || c_flag !== 1'b0 || z_flag !== 1'b1) begin
            bad++; $display("FAIL xor_flags: got iv=%b c=%b z=%b want 0 0 1", issue_valid, c_flag, z_flag);
        end
    endtask

    task automatic test_ldi();
        instr = mk(3'd6, 3'd5, 3'd0); instr_valid = 1'b1;
        cyc();
        total++;
        if (issue_valid !== 1'b0 || instr_ready !== 1'b1) begin
            bad++; $display("FAIL ldi_first: got iv=%b rdy=%b want 0 1", issue_valid, instr_ready);
        end
        instr = 9'h1A5;
        cyc();
        instr_valid = 1'b0; alu_co = 1'b1; alu_z = 1'b0;
        total++;
        if (issue_valid !== 1'b1 || alu_op !== 3'd6 || imm !== 8'hA5 || b_imm !== 1'b1 || wr_en !== 1'b1
            || wr_addr !== 3'd5 || ra_addr !== 3'd0) begin
            bad++; $display("FAIL ldi_issue: got iv=%b op=%0d imm=%h bi=%b we=%b wa=%0d ra=%0d want 1 6 a5 1 1 5 0",
                issue_valid, alu_op, imm, b_imm, wr_en, wr_addr, ra_addr);
        end
        cyc();
        total++;
        if (issue_valid !== 1'b0 || c_flag !== 1'b0 || z_flag !== 1'b1) begin
            bad++; $display("FAIL ldi_flags: got iv=%b c=%b z=%b want 0 0 1", issue_valid, c_flag, z_flag);
        end
    endtask

    task automatic test_lsh();
        instr = mk(3'd3, 3'd7, 3'b110); instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0; alu_co = 1'b1; alu_z = 1'b0;
        total++;
        if (alu_op !== 3'd3 || alu_rsh !== 1'b1 || imm !== 8'd3 || b_imm !== 1'b1 || ra_addr !== 3'd7
            || wr_addr !== 3'd7 || alu_ci !== 1'b0) begin
            bad++; $display("FAIL lsh_issue: got op=%0d rsh=%b imm=%0d bi=%b ra=%0d wa=%0d ci=%b want 3 1 3 1 7 7 0",
                alu_op, alu_rsh, imm, b_imm, ra_addr, wr_addr, alu_ci);
        end
        cyc();
        total++;
        if (c_flag !== 1'b0 || z_flag !== 1'b0) begin
            bad++; $display("FAIL lsh_flags: got c=%b z=%b want 0 0", c_flag, z_flag);
        end
    endtask

    task automatic test_mem();
        instr = mk(3'd4, 3'd2, 3'd3); instr_valid = 1'b1; alu_co = 1'b1; alu_z = 1'b1;
        cyc();
        total++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || ra_addr !== 3'd2 || rb_addr !== 3'd3 || wr_en !== 1'b0) begin
            bad++; $display("FAIL str_issue: got mw=%b mr=%b ra=%0d rb=%0d we=%b want 1 0 2 3 0", mem_wr, mem_rd, ra_addr, rb_addr, wr_en);
        end
        instr = mk(3'd5, 3'd4, 3'd1);
        cyc();
        instr_valid = 1'b0;
        total++;
        if (issue_valid !== 1'b1 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || rb_addr !== 3'd1 || ra_addr !== 3'd0
            || wr_en !== 1'b1 || wr_addr !== 3'd4) begin
            bad++; $display("FAIL ldm_issue: got iv=%b mr=%b mw=%b rb=%0d ra=%0d we=%b wa=%0d want 1 1 0 1 0 1 4",
                issue_valid, mem_rd, mem_wr, rb_addr, ra_addr, wr_en, wr_addr);
        end
        cyc();
        total++;
        if (c_flag !== 1'b0 || z_flag !== 1'b0) begin
            bad++; $display("FAIL mem_flags: got c=%b z=%b want 0 0", c_flag, z_flag);
        end
    endtask

    task automatic test_stall();
        instr = mk(3'd1, 3'd6, 3'd0); instr_valid = 1'b1;
        cyc();
        stall = 1'b1; alu_co = 1'b1; alu_z = 1'b1;
        instr = mk(3'd2, 3'd1, 3'd1);
        #1;
        total++;
        if (instr_ready !== 1'b0) begin
            bad++; $display("FAIL stall_ready: got %b want 0", instr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (issue_valid !== 1'b1 || alu_op !== 3'd1 || ra_addr !== 3'd6 || instr_ready !== 1'b0
                || c_flag !== 1'b0 || z_flag !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d: got iv=%b op=%0d ra=%0d rdy=%b c=%b z=%b want 1 1 6 0 0 0",
                    i, issue_valid, alu_op, ra_addr, instr_ready, c_flag, z_flag);
            end
        end
        stall = 1'b0;
        cyc();
        instr_valid = 1'b0; alu_co = 1'b0; alu_z = 1'b0;
        total++;
        if (c_flag !== 1'b1 || z_flag !== 1'b1 || issue_valid !== 1'b1 || alu_op !== 3'd2) begin
            bad++; $display("FAIL stall_release: got c=%b z=%b iv=%b op=%0d want 1 1 1 2", c_flag, z_flag, issue_valid, alu_op);
        end
        cyc();
        total++;
        if (c_flag !== 1'b0 || z_flag !== 1'b0 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL stall_after: got c=%b z=%b iv=%b want 0 0 0", c_flag, z_flag, issue_valid);
        end
    endtask

    task automatic test_reset_imm();
        instr = mk(3'd6, 3'd2, 3'd0); instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        do_reset();
        total++;
        if (issue_valid !== 1'b0) begin
            bad++; $display("FAIL imm_reset_iv: got %b want 0", issue_valid);
        end
        instr = mk(3'd1, 3'd1, 3'd1); instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        total++;
        if (issue_valid !== 1'b1 || alu_op !== 3'd1 || b_imm !== 1'b0 || imm !== 8'd0) begin
            bad++; $display("FAIL imm_reset_next: got iv=%b op=%0d bi=%b imm=%h want 1 1 0 00", issue_valid, alu_op, b_imm, imm);
        end
        cyc();
    endtask

    task automatic test_halt();
        instr = mk(3'd1, 3'd3, 3'd3); instr_valid = 1'b1; alu_co = 1'b1; alu_z = 1'b0;
        cyc();
        instr = 9'b111_000_000;
        cyc();
        instr = mk(3'd0, 3'd1, 3'd1);
        total++;
        if (halted !== 1'b1 || instr_ready !== 1'b0 || issue_valid !== 1'b0 || c_flag !== 1'b1) begin
            bad++; $display("FAIL halt_enter: got h=%b rdy=%b iv=%b c=%b want 1 0 0 1", halted, instr_ready, issue_valid, c_flag);
        end
        cyc(); cyc();
        total++;
        if (halted !== 1'b1 || instr_ready !== 1'b0 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL halt_hold: got h=%b rdy=%b iv=%b want 1 0 0", halted, instr_ready, issue_valid);
        end
        do_reset();
        total++;
        if (halted !== 1'b0 || instr_ready !== 1'b1 || c_flag !== 1'b0) begin
            bad++; $display("FAIL halt_reset: got h=%b rdy=%b c=%b want 0 1 0", halted, instr_ready, c_flag);
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 9'd0; stall = 1'b0; alu_co = 1'b0; alu_z = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_ldi();
        test_lsh();
        test_mem();
        test_stall();
        test_reset_imm();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
